// File: rtl/adc_acq_sequencer_if.sv
// Handshake and configuration bundle between the acquisition sequencer and
// the capture block / readout side / HPS register bank.
interface adc_acq_sequencer_if #(
  parameter int unsigned SHOT_W = 16
);
  logic              iArm;
  logic              iAbort;
  logic [31:0]       iTrigDelay;
  logic [SHOT_W-1:0] iShotCount;
  logic [31:0]       iShotGap;
  logic              iTriggerAck;
  logic              iTransmitReady;
  logic              iReadoutDone;
  logic              oTxTrigger;
  logic              oCaptureReset;
  logic              oReadoutReq;
  logic              oBusy;
  logic              oDone;
  logic              oError;
  logic [SHOT_W-1:0] oShotIdx;
  logic [2:0]        oState;

  modport master (
    input  iArm, iAbort, iTrigDelay, iShotCount, iShotGap,
           iTriggerAck, iTransmitReady, iReadoutDone,
    output oTxTrigger, oCaptureReset, oReadoutReq, oBusy, oDone, oError,
           oShotIdx, oState
  );

  modport slave (
    output iArm, iAbort, iTrigDelay, iShotCount, iShotGap,
           iTriggerAck, iTransmitReady, iReadoutDone,
    input  oTxTrigger, oCaptureReset, oReadoutReq, oBusy, oDone, oError,
           oShotIdx, oState
  );
endinterface

// File: rtl/adc_acq_sequencer.sv
// Frame-clock shot sequencer: delay, trigger, capture, readout, gap, repeat.
// Define ACQ_TIMEOUT_EN to enable the handshake watchdog and ERROR state.
//
// state   | meaning
// IDLE    | waiting for arm edge
// DELAY   | counting trigger delay
// TRIG    | trigger asserted, waiting for ack
// CAPTURE | waiting for capture buffer full
// READOUT | buffer offered to readout, waiting for done
// GAP     | counting inter-shot gap
// DONE    | run complete, waiting for arm edge
// ERROR   | watchdog expired, waiting for arm edge
module adc_acq_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
  parameter int unsigned SHOT_W         = 16
) (
  input  logic                frameCLKINP,
  input  logic                iStateResetN,
  adc_acq_sequencer_if.master acq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_TRIG    = 3'd2,
    S_CAPTURE = 3'd3,
    S_READOUT = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              arm_q, arm_edge;
  logic [31:0]       delay_q, delay_d, gap_q, gap_d, cnt_q, cnt_d;
  logic [SHOT_W-1:0] count_q, count_d, idx_q, idx_d;
  logic              tx_q, tx_d, rdreq_q, rdreq_d, crst_q, crst_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              last_shot, timeout;

  assign arm_edge  = acq.iArm & ~arm_q;
  assign last_shot = (idx_q == count_q - SHOT_W'(1));

  always_ff @(posedge frameCLKINP) begin
    if (!iStateResetN) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      delay_q <= '0;
      gap_q   <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b0;
      rdreq_q <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= acq.iArm;
      delay_q <= delay_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rdreq_q <= rdreq_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acq.iAbort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (arm_edge) state_d = S_DELAY;
        S_DELAY:   if (cnt_q == '0) state_d = S_TRIG;
        S_TRIG:    if (acq.iTriggerAck) state_d = S_CAPTURE;
                   else if (timeout) state_d = S_ERROR;
        S_CAPTURE: if (acq.iTransmitReady) state_d = S_READOUT;
                   else if (timeout) state_d = S_ERROR;
        S_READOUT: if (acq.iReadoutDone) state_d = last_shot ? S_DONE : S_GAP;
                   else if (timeout) state_d = S_ERROR;
        S_GAP:     if (cnt_q == '0) state_d = S_DELAY;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Abort and watchdog expiry share the same shutdown: drop requests, pulse capture reset.
  always_comb begin
    delay_d = delay_q;
    gap_d   = gap_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rdreq_d = rdreq_q;
    crst_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    if (acq.iAbort || (state_d == S_ERROR && state_q != S_ERROR)) begin
      tx_d    = 1'b0;
      rdreq_d = 1'b0;
      busy_d  = 1'b0;
      crst_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (arm_edge) begin
            delay_d = acq.iTrigDelay;
            gap_d   = acq.iShotGap;
            count_d = (acq.iShotCount == '0) ? SHOT_W'(1) : acq.iShotCount;
            idx_d   = '0;
            cnt_d   = acq.iTrigDelay;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) tx_d = 1'b1;
          else             cnt_d = cnt_q - 32'd1;
        end
        S_TRIG:    if (acq.iTriggerAck) tx_d = 1'b0;
        S_CAPTURE: if (acq.iTransmitReady) rdreq_d = 1'b1;
        S_READOUT: begin
          if (acq.iReadoutDone) begin
            rdreq_d = 1'b0;
            crst_d  = 1'b1;
            if (last_shot) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + SHOT_W'(1);
              cnt_d = gap_q;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == '0) cnt_d = delay_q;
          else             cnt_d = cnt_q - 32'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ACQ_TIMEOUT_EN
  logic [23:0] wd_q, wd_d;
  logic        err_q, err_d, wd_run;

  assign wd_run  = (state_q == S_TRIG) || (state_q == S_CAPTURE) || (state_q == S_READOUT);
  assign timeout = wd_run && (wd_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    wd_d  = (wd_run && state_d == state_q) ? wd_q + 24'd1 : '0;
    err_d = err_q;
    if (state_d == S_ERROR && state_q != S_ERROR)
      err_d = 1'b1;
    else if (state_d == S_DELAY && state_q inside {S_IDLE, S_DONE, S_ERROR})
      err_d = 1'b0;
  end

  always_ff @(posedge frameCLKINP) begin
    if (!iStateResetN) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign acq.oError = err_q;
`else
  assign timeout    = 1'b0;
  assign acq.oError = 1'b0;
`endif

  assign acq.oTxTrigger    = tx_q;
  assign acq.oCaptureReset = crst_q;
  assign acq.oReadoutReq   = rdreq_q;
  assign acq.oBusy         = busy_q;
  assign acq.oDone         = done_q;
  assign acq.oShotIdx      = idx_q;
  assign acq.oState        = state_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Scoreboard bench for adc_acq_sequencer: stimulus queues expected output
// events with exact cycle numbers, a negedge monitor pops and compares them.
module tb_adc_acq_sequencer;

  localparam int EV_TX   = 0;
  localparam int EV_RD   = 1;
  localparam int EV_CRST = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];

  adc_acq_sequencer_if #(.SHOT_W(16)) acq ();

  adc_acq_sequencer #(
    .TIMEOUT_CYCLES(24'd100),
    .SHOT_W        (16)
  ) dut (
    .frameCLKINP (clk),
    .iStateResetN(rst_n),
    .acq         (acq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input int i);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.idx  = i;
    sb.push_back(e);
  endtask

  task automatic got(input int k);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d idx=%0d, want none",
               k, cyc, acq.oShotIdx);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.idx != int'(acq.oShotIdx)) begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d idx=%0d, want kind=%0d cyc=%0d idx=%0d",
                 k, cyc, acq.oShotIdx, e.kind, e.cyc, e.idx);
      end
    end
  endtask

  // Monitor: rising edges of trigger/readout/done/error, every cycle of capture reset
  bit tx_p = 0, rd_p = 0, done_p = 0, err_p = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (acq.oTxTrigger && !tx_p) got(EV_TX);
      if (acq.oReadoutReq && !rd_p) got(EV_RD);
      if (acq.oCaptureReset) got(EV_CRST);
      if (acq.oDone && !done_p) got(EV_DONE);
      if (acq.oError && !err_p) got(EV_ERR);
    end
    tx_p   = acq.oTxTrigger;
    rd_p   = acq.oReadoutReq;
    done_p = acq.oDone;
    err_p  = acq.oError;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic arm_pulse(input int d, input int n, input int g);
    acq.iTrigDelay = 32'(d);
    acq.iShotCount = 16'(n);
    acq.iShotGap   = 32'(g);
    acq.iArm       = 1'b1;
    tick(1);
    acq.iArm       = 1'b0;
  endtask

  // One shot with trigger expected at cycle t: ack 2 cycles later, then ready, then done.
  task automatic shot(input int t, input int idx, input bit last);
    expect_ev(EV_TX, t, idx);
    expect_ev(EV_RD, t + 4, idx);
    expect_ev(EV_CRST, t + 5, last ? idx : idx + 1);
    if (last) expect_ev(EV_DONE, t + 5, idx);
    wait_until(t + 2);
    chk("tx_hold", acq.oTxTrigger, 1);
    acq.iTriggerAck = 1'b1;
    tick(1);
    acq.iTriggerAck = 1'b0;
    chk("tx_drop", acq.oTxTrigger, 0);
    acq.iTransmitReady = 1'b1;
    tick(1);
    acq.iTransmitReady = 1'b0;
    acq.iReadoutDone   = 1'b1;
    tick(1);
    acq.iReadoutDone   = 1'b0;
    chk("shot_exit_state", acq.oState, last ? 6 : 5);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int c, c2;
    rst_n              = 1'b0;
    acq.iArm           = 1'b0;
    acq.iAbort         = 1'b0;
    acq.iTrigDelay     = '0;
    acq.iShotCount     = '0;
    acq.iShotGap       = '0;
    acq.iTriggerAck    = 1'b0;
    acq.iTransmitReady = 1'b0;
    acq.iReadoutDone   = 1'b0;

    tick(3);
    chk("rst_crst", acq.oCaptureReset, 1);
    chk("rst_tx", acq.oTxTrigger, 0);
    chk("rst_rdreq", acq.oReadoutReq, 0);
    chk("rst_busy", acq.oBusy, 0);
    chk("rst_done", acq.oDone, 0);
    chk("rst_err", acq.oError, 0);
    chk("rst_idx", acq.oShotIdx, 0);
    chk("rst_state", acq.oState, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_crst", acq.oCaptureReset, 0);
    mon_en = 1'b1;

    // single shot, delay 5
    c = cyc;
    arm_pulse(5, 1, 0);
    chk("t1_busy", acq.oBusy, 1);
    shot(c + 7, 0, 1);
    chk("t1_busy_end", acq.oBusy, 0);
    chk("t1_done", acq.oDone, 1);

    // three shots, gap 10, delay 0: 12 cycles from readout exit to next trigger
    c = cyc;
    arm_pulse(0, 3, 10);
    chk("t2_done_clr", acq.oDone, 0);
    chk("t2_busy", acq.oBusy, 1);
    shot(c + 2, 0, 0);
    shot(c + 19, 1, 0);
    shot(c + 36, 2, 1);
    chk("t2_idx_final", acq.oShotIdx, 2);

    // count 0 means one shot; mid-run arm and config changes ignored
    c = cyc;
    arm_pulse(3, 0, 7);
    tick(1);
    acq.iArm       = 1'b1;
    acq.iTrigDelay = 32'd50;
    acq.iShotCount = 16'd5;
    acq.iShotGap   = 32'd99;
    tick(1);
    acq.iArm       = 1'b0;
    shot(c + 5, 0, 1);
    chk("t3_done", acq.oDone, 1);

    // abort in DONE keeps oDone
    c = cyc;
    acq.iAbort = 1'b1;
    expect_ev(EV_CRST, c + 1, 0);
    tick(1);
    acq.iAbort = 1'b0;
    chk("abort_done_state", acq.oState, 0);
    chk("abort_done_kept", acq.oDone, 1);

    // abort during CAPTURE
    c = cyc;
    arm_pulse(2, 2, 0);
    expect_ev(EV_TX, c + 4, 0);
    wait_until(c + 6);
    chk("t4_tx", acq.oTxTrigger, 1);
    acq.iTriggerAck = 1'b1;
    tick(1);
    acq.iTriggerAck = 1'b0;
    chk("t4_capture", acq.oState, 3);
    acq.iAbort = 1'b1;
    expect_ev(EV_CRST, c + 8, 0);
    tick(1);
    acq.iAbort = 1'b0;
    chk("t4_state", acq.oState, 0);
    chk("t4_rdreq", acq.oReadoutReq, 0);
    chk("t4_busy", acq.oBusy, 0);
    chk("t4_done", acq.oDone, 0);

    // abort coincident with arm edge: arm consumed, no start
    c = cyc;
    acq.iAbort = 1'b1;
    acq.iArm   = 1'b1;
    expect_ev(EV_CRST, c + 1, 0);
    tick(1);
    acq.iAbort = 1'b0;
    chk("t5_state", acq.oState, 0);
    tick(2);
    chk("t5_state_hold", acq.oState, 0);
    chk("t5_busy", acq.oBusy, 0);
    acq.iArm = 1'b0;
    tick(1);

`ifdef ACQ_TIMEOUT_EN
    // no ack: error 100 cycles after TRIG entry, next arm recovers
    c = cyc;
    arm_pulse(0, 1, 0);
    expect_ev(EV_TX, c + 2, 0);
    expect_ev(EV_CRST, c + 102, 0);
    expect_ev(EV_ERR, c + 102, 0);
    wait_until(c + 101);
    chk("to_not_yet", acq.oError, 0);
    tick(1);
    chk("to_err", acq.oError, 1);
    chk("to_tx", acq.oTxTrigger, 0);
    chk("to_state", acq.oState, 7);
    chk("to_busy", acq.oBusy, 0);
    c2 = cyc;
    arm_pulse(0, 1, 0);
    chk("to_err_clr", acq.oError, 0);
    chk("to_rearm_busy", acq.oBusy, 1);
    shot(c2 + 2, 0, 1);
`endif

    tick(20);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
